multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle MIPS control FSM; the sequential successor to the single-cycle decoder.
//  Steps each instruction through IF/ID/EX/MEM/WB states with configurable memory wait cycles.
//  Traps unsupported opcodes into an exception state.
//  Drives the shared-memory multi-cycle datapath: PC, IR, regfile, ALU and memory muxes.
// PARAMETERS
//  MEM_LAT  0  extra wait cycles per memory access (IF and MEM), legal 0..7
//  ALUOP_W  4  ALUOp width, >=4; bit3 = OpCode[0], bits[2:0] = op class, upper bits 0
//  EXC_EN   1  1: illegal opcode -> S_EXC; 0: illegal opcode treated as NOP (back to IF)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  OpCode     in   6        IR[31:26], valid from ID onward
//  Funct      in   6        IR[5:0]
//  PCWrite    out  1        unconditional PC load
//  PCWriteCond out 1        PC load if ALU Zero (beq)
//  IorD       out  1        0: mem addr = PC, 1: mem addr = ALUOut
//  MemRead    out  1        memory read strobe
//  MemWrite   out  1        memory write strobe
//  IRWrite    out  1        latch instruction register
//  MemtoReg   out  2        00 ALUOut, 01 MDR, 10 PC (link)
//  RegDst     out  2        00 rt, 01 rd, 10 $31
//  RegWrite   out  1        regfile write enable
//  ExtOp      out  1        1 sign-extend, 0 zero-extend (andi)
//  LuOp       out  1        lui: immediate << 16
//  ALUSrcA    out  2        00 PC, 01 rs, 10 shamt
//  ALUSrcB    out  2        00 rt, 01 const 4, 10 imm, 11 imm<<2
//  ALUOp      out  ALUOP_W  000 add, 001 sub, 010 R-type(Funct), 100 and, 101 slt
//  PCSource   out  2        00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
//  Exception  out  1        one-cycle pulse in S_EXC
//  state_o    out  3        current state (debug/verification)
// BEHAVIOUR
//  States: IF=0, IFW=1, ID=2, EX=3, MEM=4, MEMW=5, WB=6, EXC=7. Reset -> IF; all outputs 0 while reset low.
//  Outputs are combinational from state (+OpCode/Funct in ID/EX/MEM/WB); no registered outputs.
//  IF: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00.
//   MEM_LAT=0: IRWrite=PCWrite=1 in IF, next ID. Else IF->IFW; wait counter loads MEM_LAT-1.
//   IFW holds MemRead; IRWrite=PCWrite=1 only in the cycle counter==0, then ID.
//  ID: ALUSrcA=00, ALUSrcB=11, ALUOp=add (branch target precompute).
//   j: PCWrite=1, PCSource=10 -> IF. jal: additionally RegWrite=1, RegDst=10, MemtoReg=10.
//   jr (00/08): PCWrite=1, PCSource=00, ALUSrcA=01, ALUSrcB=00, ALUOp=add -> IF.
//   jalr (00/09): as jr plus RegWrite=1, RegDst=01, MemtoReg=10 -> IF.
//   Legal = 00,02,03,04,08,09,0a,0b,0c,0f,23,2b; any other -> EXC (EXC_EN=1) or IF.
//   Otherwise -> EX.
//  EX: R-type: ALUSrcA=01 (10 for sll/srl/sra Funct 00/02/03), ALUSrcB=00, ALUOp=010 -> WB.
//   lw/sw/addi/addiu/lui/slti/sltiu/andi: ALUSrcA=01, ALUSrcB=10, ALUOp per class.
//   lw/sw -> MEM; others -> WB. ExtOp=0 only for andi; LuOp=1 only for lui.
//   beq: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01 -> IF.
//  MEM: IorD=1; lw MemRead=1, sw MemWrite=1. Wait handling identical to IF via MEMW.
//   Strobes held for all 1+MEM_LAT cycles. Last cycle: lw -> WB, sw -> IF.
//  WB: RegWrite=1; lw RegDst=00, MemtoReg=01; I-type ALU RegDst=00, MemtoReg=00.
//   R-type RegDst=01, MemtoReg=00. -> IF.
//  EXC: Exception=1, PCWrite=1, PCSource=11, RegWrite=1, RegDst=10, MemtoReg=10 (EPC->$31) -> IF.
//  CPI: j/jr=2, beq=3, R/I-ALU/sw=4, lw=5, each +MEM_LAT per memory access (lw/sw +2*MEM_LAT).
//  PCWrite and PCWriteCond are never both 1. MemRead and MemWrite are never both 1.
//  Async reset mid-instruction (incl. wait states) aborts immediately; counter cleared.
//  Execution resumes in IF on the first rising edge after release.
// TESTING
//  1 MEM_LAT=0, add (00/20): states IF,ID,EX,WB; WB RegWrite=1 RegDst=01 ALUOp=010.
//  2 MEM_LAT=2, lw (23): IF,IFW,IFW,ID,EX,MEM,MEMW,MEMW,WB = 9 cycles.
//    MemRead held in IF/IFW and MEM/MEMW; IRWrite only in 3rd fetch cycle.
//  3 jal (03): IF,ID only; ID drives PCWrite=1 PCSource=10 RegWrite=1 RegDst=10 MemtoReg=10.
//  4 beq (04) in EX: PCWriteCond=1 PCSource=01 ALUOp=001; next state IF.
//    OpCode 3f: EXC, Exception pulse 1 cycle, PCSource=11; EXC_EN=0 -> ID->IF, no writes.
//  5 reset low during MEMW of sw: all outputs 0 asynchronously, state_o=0.
//    After release, IF with MemRead=1 on the next edge.
//  6 sll (00/00): EX ALUSrcA=10. andi (0c): ExtOp=0. lui (0f): LuOp=1 ALUSrcB=10.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: steps IF/ID/EX/MEM/WB with optional memory wait
// states and traps unsupported opcodes into an exception state.
module multicycle_control #(
   parameter int unsigned MEM_LAT = 0,
   parameter int unsigned ALUOP_W = 4,
   parameter bit          EXC_EN  = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         Funct,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ExtOp,
   output logic               LuOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSource,
   output logic               Exception,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_IFW  = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_MEMW = 3'd5,
      S_WB   = 3'd6,
      S_EXC  = 3'd7
   } state_t;

   localparam logic [2:0] WAIT_INIT = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_RTY = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state;
   logic [2:0] wait_cnt;
   logic [3:0] alu4;

   logic op_r, op_j, op_jal, op_beq, op_addi, op_addiu, op_slti, op_sltiu;
   logic op_andi, op_lui, op_lw, op_sw;
   logic is_jr, is_jalr, is_shift, is_jump, legal;
   logic fetch_last, mem_last;

   assign op_r     = (OpCode == 6'h00);
   assign op_j     = (OpCode == 6'h02);
   assign op_jal   = (OpCode == 6'h03);
   assign op_beq   = (OpCode == 6'h04);
   assign op_addi  = (OpCode == 6'h08);
   assign op_addiu = (OpCode == 6'h09);
   assign op_slti  = (OpCode == 6'h0a);
   assign op_sltiu = (OpCode == 6'h0b);
   assign op_andi  = (OpCode == 6'h0c);
   assign op_lui   = (OpCode == 6'h0f);
   assign op_lw    = (OpCode == 6'h23);
   assign op_sw    = (OpCode == 6'h2b);

   assign is_jr    = op_r && (Funct == 6'h08);
   assign is_jalr  = op_r && (Funct == 6'h09);
   assign is_shift = op_r && ((Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03));
   assign is_jump  = op_j || op_jal || is_jr || is_jalr;
   assign legal    = op_r || op_j || op_jal || op_beq || op_addi || op_addiu || op_slti ||
                     op_sltiu || op_andi || op_lui || op_lw || op_sw;

   // With MEM_LAT=0 the access completes in IF/MEM itself; otherwise on the last wait cycle.
   assign fetch_last = ((state == S_IF)  && (MEM_LAT == 0)) || ((state == S_IFW)  && (wait_cnt == '0));
   assign mem_last   = ((state == S_MEM) && (MEM_LAT == 0)) || ((state == S_MEMW) && (wait_cnt == '0));

   assign state_o = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IF;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IF, S_IFW: begin
               if (fetch_last)        state <= S_ID;
               else if (state == S_IF) begin
                  state    <= S_IFW;
                  wait_cnt <= WAIT_INIT;
               end else               wait_cnt <= wait_cnt - 1'b1;
            end
            S_ID: begin
               if (is_jump)     state <= S_IF;
               else if (!legal) state <= EXC_EN ? S_EXC : S_IF;
               else             state <= S_EX;
            end
            S_EX: begin
               if (op_beq)              state <= S_IF;
               else if (op_lw || op_sw) state <= S_MEM;
               else                     state <= S_WB;
            end
            S_MEM, S_MEMW: begin
               if (mem_last)            state <= op_lw ? S_WB : S_IF;
               else if (state == S_MEM) begin
                  state    <= S_MEMW;
                  wait_cnt <= WAIT_INIT;
               end else                 wait_cnt <= wait_cnt - 1'b1;
            end
            default: state <= S_IF;
         endcase
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuOp        = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      Exception   = 1'b0;
      alu4        = '0;
      if (reset) begin
         case (state)
            S_IF, S_IFW: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               if (fetch_last) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end
            end
            S_ID: begin
               // Sign-extend here so the branch target precompute uses imm<<2 correctly.
               ALUSrcB = 2'b11;
               ExtOp   = 1'b1;
               if (op_j || op_jal) begin
                  PCWrite  = 1'b1;
                  PCSource = 2'b10;
               end
               if (op_jal) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b10;
                  MemtoReg = 2'b10;
               end
               if (is_jr || is_jalr) begin
                  PCWrite  = 1'b1;
                  ALUSrcA  = 2'b01;
                  ALUSrcB  = 2'b00;
               end
               if (is_jalr) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b01;
                  MemtoReg = 2'b10;
               end
            end
            S_EX, S_WB: begin
               // WB keeps the EX ALU setup so ALUOut-based write data stays stable.
               alu4[3] = OpCode[0];
               if (op_r) begin
                  ALUSrcA   = is_shift ? 2'b10 : 2'b01;
                  alu4[2:0] = ALU_RTY;
               end else if (op_beq) begin
                  ALUSrcA   = 2'b01;
                  alu4[2:0] = ALU_SUB;
               end else begin
                  ALUSrcA   = 2'b01;
                  ALUSrcB   = 2'b10;
                  ExtOp     = !op_andi;
                  LuOp      = op_lui;
                  if (op_andi)                 alu4[2:0] = ALU_AND;
                  else if (op_slti || op_sltiu) alu4[2:0] = ALU_SLT;
                  else                         alu4[2:0] = ALU_ADD;
               end
               if ((state == S_EX) && op_beq) begin
                  PCWriteCond = 1'b1;
                  PCSource    = 2'b01;
               end
               if (state == S_WB) begin
                  RegWrite = 1'b1;
                  if (op_lw)     MemtoReg = 2'b01;
                  else if (op_r) RegDst   = 2'b01;
               end
            end
            S_MEM, S_MEMW: begin
               IorD     = 1'b1;
               MemRead  = op_lw;
               MemWrite = op_sw;
            end
            S_EXC: begin
               Exception = 1'b1;
               PCWrite   = 1'b1;
               PCSource  = 2'b11;
               RegWrite  = 1'b1;
               RegDst    = 2'b10;
               MemtoReg  = 2'b10;
            end
            default: ;
         endcase
      end
      ALUOp = ALUOP_W'(alu4);
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (MEM_LAT=0/EXC_EN=1 and
// MEM_LAT=2/EXC_EN=0/ALUOP_W=6) compared cycle by cycle against hand-built control words.
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       ext_op;
      logic       lu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [5:0] alu_op;
      logic [1:0] pc_source;
      logic       exception;
      logic [2:0] state;
   } ctrl_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OpCode;
   logic [5:0] Funct;

   always #5 clk = ~clk;

   logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_ext, a_lu, a_exc;
   logic [1:0] a_m2r, a_rdst, a_srca, a_srcb, a_pcsrc;
   logic [3:0] a_aluop;
   logic [2:0] a_st;
   logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_ext, b_lu, b_exc;
   logic [1:0] b_m2r, b_rdst, b_srca, b_srcb, b_pcsrc;
   logic [5:0] b_aluop;
   logic [2:0] b_st;
   ctrl_t      oa, ob;

   assign oa = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_ext, a_lu,
                a_srca, a_srcb, {2'b00, a_aluop}, a_pcsrc, a_exc, a_st};
   assign ob = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_ext, b_lu,
                b_srca, b_srcb, b_aluop, b_pcsrc, b_exc, b_st};

   multicycle_control #(.MEM_LAT(0), .ALUOP_W(4), .EXC_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
      .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
      .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
      .RegWrite(a_rw), .ExtOp(a_ext), .LuOp(a_lu), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
      .ALUOp(a_aluop), .PCSource(a_pcsrc), .Exception(a_exc), .state_o(a_st)
   );

   multicycle_control #(.MEM_LAT(2), .ALUOP_W(6), .EXC_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
      .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
      .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
      .RegWrite(b_rw), .ExtOp(b_ext), .LuOp(b_lu), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
      .ALUOp(b_aluop), .PCSource(b_pcsrc), .Exception(b_exc), .state_o(b_st)
   );

   int checks = 0;
   int passed = 0;

   function automatic ctrl_t fetch_c(input logic [2:0] st, input logic last);
      ctrl_t c = '0;
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write  = last;
      c.pc_write  = last;
      c.state     = st;
      return c;
   endfunction

   function automatic ctrl_t decode_c();
      ctrl_t c = '0;
      c.alu_src_b = 2'b11;
      c.ext_op    = 1'b1;
      c.state     = 3'd2;
      return c;
   endfunction

   task automatic start(input logic [5:0] op, input logic [5:0] fn);
      @(negedge clk);
      reset  = 1'b0;
      OpCode = op;
      Funct  = fn;
      @(negedge clk);
      reset  = 1'b1;
   endtask

   task automatic test_reset;
      reset  = 1'b0;
      OpCode = 6'h23;
      Funct  = 6'h00;
      #1;
      checks++;
      if (oa !== ctrl_t'('0)) $display("FAIL reset_a: got %h expected %h", oa, ctrl_t'('0));
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (ob !== ctrl_t'('0)) $display("FAIL reset_b: got %h expected %h", ob, ctrl_t'('0));
      else passed++;
   endtask

   task automatic test_add;
      ctrl_t e[$];
      ctrl_t c;
      e.push_back(fetch_c(3'd0, 1'b1));
      e.push_back(decode_c());
      c = '0; c.alu_src_a = 2'b01; c.alu_op = 6'h02; c.state = 3'd3;
      e.push_back(c);
      c.reg_write = 1'b1; c.reg_dst = 2'b01; c.state = 3'd6;
      e.push_back(c);
      e.push_back(fetch_c(3'd0, 1'b1));
      start(6'h00, 6'h20);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (oa !== e[i]) $display("FAIL add cycle %0d: got %h expected %h", i, oa, e[i]);
         else passed++;
      end
   endtask

   task automatic test_lw_wait;
      ctrl_t e[$];
      ctrl_t c;
      e.push_back(fetch_c(3'd0, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b1));
      e.push_back(decode_c());
      c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
      c.alu_op = 6'h08; c.state = 3'd3;
      e.push_back(c);
      c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.state = 3'd6;
      begin
         ctrl_t m = '0;
         m.iord = 1'b1; m.mem_read = 1'b1; m.state = 3'd4;
         e.push_back(m);
         m.state = 3'd5;
         e.push_back(m);
         e.push_back(m);
      end
      e.push_back(c);
      e.push_back(fetch_c(3'd0, 1'b0));
      start(6'h23, 6'h00);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (ob !== e[i]) $display("FAIL lw_wait cycle %0d: got %h expected %h", i, ob, e[i]);
         else passed++;
      end
   endtask

   task automatic test_jumps;
      ctrl_t e[$];
      ctrl_t c;
      // jal
      e.push_back(fetch_c(3'd0, 1'b1));
      c = decode_c(); c.pc_write = 1'b1; c.pc_source = 2'b10;
      c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      e.push_back(c);
      e.push_back(fetch_c(3'd0, 1'b1));
      start(6'h03, 6'h00);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (oa !== e[i]) $display("FAIL jal cycle %0d: got %h expected %h", i, oa, e[i]);
         else passed++;
      end
      // jalr
      e.delete();
      e.push_back(fetch_c(3'd0, 1'b1));
      c = decode_c(); c.alu_src_a = 2'b01; c.alu_src_b = 2'b00; c.pc_write = 1'b1;
      c.reg_write = 1'b1; c.reg_dst = 2'b01; c.mem_to_reg = 2'b10;
      e.push_back(c);
      e.push_back(fetch_c(3'd0, 1'b1));
      start(6'h00, 6'h09);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (oa !== e[i]) $display("FAIL jalr cycle %0d: got %h expected %h", i, oa, e[i]);
         else passed++;
      end
   endtask

   task automatic test_beq;
      ctrl_t e[$];
      ctrl_t c;
      e.push_back(fetch_c(3'd0, 1'b1));
      e.push_back(decode_c());
      c = '0; c.alu_src_a = 2'b01; c.alu_op = 6'h01; c.pc_write_cond = 1'b1;
      c.pc_source = 2'b01; c.state = 3'd3;
      e.push_back(c);
      e.push_back(fetch_c(3'd0, 1'b1));
      start(6'h04, 6'h00);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (oa !== e[i]) $display("FAIL beq cycle %0d: got %h expected %h", i, oa, e[i]);
         else passed++;
      end
   endtask

   task automatic test_exception;
      ctrl_t ea[$];
      ctrl_t eb[$];
      ctrl_t c;
      ea.push_back(fetch_c(3'd0, 1'b1));
      ea.push_back(decode_c());
      c = '0; c.exception = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b11;
      c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.state = 3'd7;
      ea.push_back(c);
      ea.push_back(fetch_c(3'd0, 1'b1));
      eb.push_back(fetch_c(3'd0, 1'b0));
      eb.push_back(fetch_c(3'd1, 1'b0));
      eb.push_back(fetch_c(3'd1, 1'b1));
      eb.push_back(decode_c());
      eb.push_back(fetch_c(3'd0, 1'b0));
      start(6'h3f, 6'h00);
      for (int i = 0; i < eb.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (i < ea.size()) begin
            checks++;
            if (oa !== ea[i]) $display("FAIL exc_en cycle %0d: got %h expected %h", i, oa, ea[i]);
            else passed++;
         end
         checks++;
         if (ob !== eb[i]) $display("FAIL exc_dis cycle %0d: got %h expected %h", i, ob, eb[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_sw;
      ctrl_t e[$];
      ctrl_t c;
      e.push_back(fetch_c(3'd0, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b1));
      e.push_back(decode_c());
      c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
      c.alu_op = 6'h08; c.state = 3'd3;
      e.push_back(c);
      c = '0; c.iord = 1'b1; c.mem_write = 1'b1; c.state = 3'd4;
      e.push_back(c);
      c.state = 3'd5;
      e.push_back(c);
      start(6'h2b, 6'h00);
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (ob !== e[i]) $display("FAIL sw cycle %0d: got %h expected %h", i, ob, e[i]);
         else passed++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ob !== ctrl_t'('0)) $display("FAIL sw_abort: got %h expected %h", ob, ctrl_t'('0));
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      e.delete();
      e.push_back(fetch_c(3'd0, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b0));
      e.push_back(fetch_c(3'd1, 1'b1));
      e.push_back(decode_c());
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (ob !== e[i]) $display("FAIL sw_resume cycle %0d: got %h expected %h", i, ob, e[i]);
         else passed++;
      end
   endtask

   task automatic test_alu_variants;
      logic [5:0] ops [3];
      logic [5:0] fns [3];
      ops[0] = 6'h00; fns[0] = 6'h00;
      ops[1] = 6'h0c; fns[1] = 6'h00;
      ops[2] = 6'h0f; fns[2] = 6'h00;
      for (int k = 0; k < 3; k++) begin
         ctrl_t e[$];
         ctrl_t c;
         c = '0; c.state = 3'd3;
         if (k == 0) begin
            c.alu_src_a = 2'b10; c.alu_op = 6'h02;
         end else if (k == 1) begin
            c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b0; c.alu_op = 6'h04;
         end else begin
            c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b1; c.lu_op = 1'b1;
            c.alu_op = 6'h08;
         end
         e.push_back(fetch_c(3'd0, 1'b1));
         e.push_back(decode_c());
         e.push_back(c);
         c.reg_write = 1'b1; c.state = 3'd6;
         if (k == 0) c.reg_dst = 2'b01;
         e.push_back(c);
         e.push_back(fetch_c(3'd0, 1'b1));
         start(ops[k], fns[k]);
         for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (oa !== e[i])
               $display("FAIL alu_op%0h cycle %0d: got %h expected %h", ops[k], i, oa, e[i]);
            else passed++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_jumps();
      test_beq();
      test_exception();
      test_reset_mid_sw();
      test_alu_variants();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
